// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } cache_state_e;

  localparam int INDEX_BITS_DEFAULT = 6;
  localparam int TAG_W              = 30 - INDEX_BITS_DEFAULT;
  localparam int NUM_LINES          = 1 << INDEX_BITS_DEFAULT;

  function automatic int tag_width(input int index_bits);
    return 30 - index_bits;
  endfunction

  function automatic int line_count(input int index_bits);
    return 1 << index_bits;
  endfunction

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage with combinational lookup and one synchronous write port.
module cache_array
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int TAG_BITS   = TAG_W,
  parameter int LINES      = NUM_LINES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] lookup_index,
  input  logic [TAG_BITS-1:0]   lookup_tag,
  output logic                  hit,
  output logic [31:0]           hit_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];

  assign hit      = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
  assign hit_data = data[lookup_index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate cache FSM between the MEM stage and the SRAM controller.
module cache_controller
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic [31:0]      address,
  input  logic [31:0]      w_data,
  output logic [31:0]      r_data,
  output logic             ready,
  output logic             sram_r_en,
  output logic             sram_w_en,
  output logic [31:0]      sram_address,
  output logic [31:0]      sram_w_data,
  input  logic [31:0]      sram_r_data,
  input  logic             sram_ready,
  output logic [CNT_W-1:0] read_hits,
  output logic [CNT_W-1:0] read_misses
);

  localparam int TAG_BITS = tag_width(INDEX_BITS);
  localparam int LINES    = line_count(INDEX_BITS);

  cache_state_e state, next_state;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic [31:0]           hit_data;
  logic                  wr_en;
  logic [31:0]           wr_data;
  logic                  hit_inc;
  logic                  miss_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign index        = address[INDEX_BITS+1:2];
  assign tag          = address[31:INDEX_BITS+2];
  assign sram_address = address;
  assign sram_w_data  = w_data;

  cache_array #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS),
    .LINES     (LINES)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .lookup_index(index),
    .lookup_tag  (tag),
    .hit         (hit),
    .hit_data    (hit_data),
    .wr_en       (wr_en),
    .wr_index    (index),
    .wr_tag      (tag),
    .wr_data     (wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      read_hits   <= '0;
      read_misses <= '0;
    end else begin
      state <= next_state;
      if (hit_inc)  read_hits   <= sat_inc(read_hits);
      if (miss_inc) read_misses <= sat_inc(read_misses);
    end
  end

  // A write wins over a simultaneous read; a miss is counted only on IDLE detection.
  always_comb begin
    next_state = state;
    ready      = 1'b1;
    r_data     = '0;
    sram_r_en  = 1'b0;
    sram_w_en  = 1'b0;
    wr_en      = 1'b0;
    wr_data    = w_data;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_w_en) begin
          ready      = 1'b0;
          next_state = WRITE;
        end else if (mem_r_en) begin
          if (hit) begin
            r_data  = hit_data;
            hit_inc = 1'b1;
          end else begin
            ready      = 1'b0;
            miss_inc   = 1'b1;
            next_state = READ_MISS;
          end
        end
      end
      READ_MISS: begin
        sram_r_en = 1'b1;
        ready     = sram_ready;
        wr_data   = sram_r_data;
        if (sram_ready) begin
          r_data     = sram_r_data;
          wr_en      = !rst;
          next_state = IDLE;
        end
      end
      WRITE: begin
        sram_w_en = 1'b1;
        ready     = sram_ready;
        if (sram_ready) begin
          wr_en      = hit && !rst;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
